// File: rtl/sdio_pkg.sv
// Shared definitions for the SD/SDIO command path: FSM encoding, frame lengths,
// CRC7 polynomial and the default response timeout.
package sdio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RECV       = 2'd2,
        ST_CHECK      = 2'd3
    } sdio_state_e;

    localparam int unsigned SDIO_RESP_SHORT_LEN  = 48;
    localparam int unsigned SDIO_RESP_LONG_LEN   = 136;
    localparam logic [6:0]  SDIO_CRC7_POLY       = 7'h09;
    localparam int unsigned SDIO_NCR_MAX_DEFAULT = 64;

endpackage

// File: rtl/sdio_resp_rx_if.sv
// Command-side control and response result bundle between the host controller
// and the response receiver.
interface sdio_resp_rx_if;
    // start is a one-cycle request taken only while busy is low; resp_done and
    // resp_timeout are one-cycle completions, mutually exclusive, and the result
    // fields stay stable until the next resp_done.
    logic         start;
    logic         long_resp;
    logic         crc_chk;
    logic         cmd_in;
    logic         busy;
    logic         resp_done;
    logic         resp_timeout;
    logic         resp_crc_err;
    logic         resp_end_err;
    logic [5:0]   resp_idx;
    logic [127:0] resp_data;

    modport master (
        output start, long_resp, crc_chk, cmd_in,
        input  busy, resp_done, resp_timeout, resp_crc_err, resp_end_err,
               resp_idx, resp_data
    );

    modport slave (
        input  start, long_resp, crc_chk, cmd_in,
        output busy, resp_done, resp_timeout, resp_crc_err, resp_end_err,
               resp_idx, resp_data
    );
endinterface

// File: rtl/sdio_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, zero seed), one data bit per enabled cycle, MSB first.
module sdio_crc7
    import sdio_pkg::*;
(
    input  logic       sd_clk,
    input  logic       rstn,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);
    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = bit_i ^ crc_q[6];
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? SDIO_CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) crc_q <= '0;
        else       crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/sdio_resp_rx.sv
// Host-side SD/SDIO CMD-line response receiver (48-bit and 136-bit R2 frames).
// CRC7 checking is built only when SDIO_RESP_CRC_CHK_EN is defined.
module sdio_resp_rx
    import sdio_pkg::*;
#(
    parameter int unsigned NCR_MAX = SDIO_NCR_MAX_DEFAULT
) (
    input  logic          sd_clk,
    input  logic          rstn,
    sdio_resp_rx_if.slave rx,
    output sdio_state_e   state_o
);
    localparam logic [7:0] NCR_LAST   = 8'(NCR_MAX - 1);
    localparam logic [7:0] SHORT_LAST = 8'(SDIO_RESP_SHORT_LEN - 1);
    localparam logic [7:0] LONG_LAST  = 8'(SDIO_RESP_LONG_LEN - 1);

    sdio_state_e  state_q, state_d;
    logic [7:0]   ncr_q, ncr_d;
    logic [7:0]   bit_q, bit_d;
    logic         long_q, long_d;
    logic         chk_q, chk_d;
    logic [135:0] sr_q, sr_d;
    logic         done_q, done_d;
    logic         to_q, to_d;
    logic         crc_err_q, crc_err_d;
    logic         end_err_q, end_err_d;
    logic [5:0]   idx_q, idx_d;
    logic [127:0] data_q, data_d;
    logic         crc_mis;
    logic [7:0]   last_bit;

    assign last_bit = long_q ? LONG_LAST : SHORT_LAST;

`ifdef SDIO_RESP_CRC_CHK_EN
    logic [6:0] crc_val;
    logic       crc_en;
    // Short frames cover bits 47..8 (the zero start bit leaves a zero seed
    // unchanged); R2 covers only payload bits 127..8.
    assign crc_en = (state_q == ST_RECV) && (bit_q <= (long_q ? 8'd127 : 8'd39))
                    && (!long_q || bit_q >= 8'd8);

    sdio_crc7 u_crc7 (
        .sd_clk (sd_clk),
        .rstn   (rstn),
        .clr_i  (state_q == ST_IDLE || state_q == ST_WAIT_START),
        .en_i   (crc_en),
        .bit_i  (rx.cmd_in),
        .crc_o  (crc_val)
    );
    assign crc_mis = chk_q & (crc_val != sr_q[7:1]);
`else
    logic unused_crc;
    assign crc_mis    = 1'b0;
    assign unused_crc = chk_q ^ (^sr_q[7:1]);
`endif

    logic unused_hdr;
    assign unused_hdr = ^sr_q[135:134];

    always_comb begin
        state_d   = state_q;
        ncr_d     = ncr_q;
        bit_d     = bit_q;
        long_d    = long_q;
        chk_d     = chk_q;
        sr_d      = sr_q;
        done_d    = 1'b0;
        to_d      = 1'b0;
        crc_err_d = crc_err_q;
        end_err_d = end_err_q;
        idx_d     = idx_q;
        data_d    = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx.start) begin
                    long_d  = rx.long_resp;
                    chk_d   = rx.crc_chk;
                    ncr_d   = '0;
                    state_d = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (!rx.cmd_in) begin
                    // The register is cleared so its LSB already holds the start bit.
                    sr_d    = '0;
                    bit_d   = 8'd1;
                    state_d = ST_RECV;
                end else if (ncr_q == NCR_LAST) begin
                    to_d    = 1'b1;
                    state_d = ST_IDLE;
                end else if (ncr_q != 8'hFF) begin
                    ncr_d = ncr_q + 8'd1;
                end
            end
            ST_RECV: begin
                sr_d  = {sr_q[134:0], rx.cmd_in};
                bit_d = bit_q + 8'd1;
                if (bit_q == last_bit) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // Short and long frames share CRC/end-bit positions at the bottom.
                done_d    = 1'b1;
                crc_err_d = crc_mis;
                end_err_d = ~sr_q[0];
                idx_d     = long_q ? sr_q[133:128] : sr_q[45:40];
                data_d    = long_q ? {sr_q[127:1], 1'b0} : {96'b0, sr_q[39:8]};
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            ncr_q     <= '0;
            bit_q     <= '0;
            long_q    <= 1'b0;
            chk_q     <= 1'b0;
            sr_q      <= '0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ncr_q     <= ncr_d;
            bit_q     <= bit_d;
            long_q    <= long_d;
            chk_q     <= chk_d;
            sr_q      <= sr_d;
            done_q    <= done_d;
            to_q      <= to_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
        end
    end

    assign rx.busy         = (state_q != ST_IDLE);
    assign rx.resp_done    = done_q;
    assign rx.resp_timeout = to_q;
    assign rx.resp_crc_err = crc_err_q;
    assign rx.resp_end_err = end_err_q;
    assign rx.resp_idx     = idx_q;
    assign rx.resp_data    = data_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_sdio_resp_rx.sv
// Directed and randomized response frames checked against a field-level model
// built from polynomial long division and frame layout rules.
module tb_sdio_resp_rx;
    import sdio_pkg::*;

    localparam int NCR = 64;
`ifdef SDIO_RESP_CRC_CHK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        sd_clk = 1'b0;
    logic        rstn   = 1'b0;
    sdio_state_e state;

    sdio_resp_rx_if bus ();

    sdio_resp_rx #(.NCR_MAX(NCR)) dut (
        .sd_clk  (sd_clk),
        .rstn    (rstn),
        .rx      (bus),
        .state_o (state)
    );

    always #5 sd_clk = ~sd_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_to     = 0;
    logic [135:0] exp_q[$];
    logic [5:0]   last_idx  = '0;
    logic [127:0] last_data = '0;
    logic [135:0] f;
    int           pos;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sd_clk);
        #1;
        if (bus.resp_done === 1'b1) n_done++;
        if (bus.resp_timeout === 1'b1) n_to++;
    endtask

    // CRC7 remainder of frame bits hi..lo by long division with x^7+x^3+1.
    function automatic logic [6:0] crc_ref(input logic [135:0] v, input int hi, input int lo);
        logic [142:0] r;
        int n;
        n = hi - lo + 1;
        r = '0;
        for (int i = 0; i < n; i++) r[i + 7] = v[lo + i];
        for (int k = n + 6; k >= 7; k--)
            if (r[k]) r[k -: 8] = r[k -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [135:0] make_short(input logic [5:0] idx, input logic [31:0] arg,
                                                input logic tbit);
        logic [135:0] v;
        v = '0;
        v[46] = tbit;
        v[45:40] = idx;
        v[39:8] = arg;
        v[7:1] = crc_ref(v, 47, 8);
        v[0] = 1'b1;
        return v;
    endfunction

    function automatic logic [135:0] make_long(input logic [119:0] payload);
        logic [135:0] v;
        v = {2'b00, 6'h3F, payload, 8'h01};
        v[7:1] = crc_ref(v, 127, 8);
        return v;
    endfunction

    // Expected {crc_err, end_err, idx[5:0], data[127:0]}.
    function automatic logic [135:0] model(input logic [135:0] v, input bit lng, input bit chkc);
        logic [6:0] calc;
        logic [5:0] idx;
        logic [127:0] data;
        if (lng) begin
            calc = crc_ref(v, 127, 8);
            idx  = v[133:128];
            data = {v[127:1], 1'b0};
        end else begin
            calc = crc_ref(v, 47, 8);
            idx  = v[45:40];
            data = {96'b0, v[39:8]};
        end
        return {CRC_EN & chkc & (calc != v[7:1]), ~v[0], idx, data};
    endfunction

    task automatic pulse_start(input bit lng, input bit chkc);
        bus.start     = 1'b1;
        bus.long_resp = lng;
        bus.crc_chk   = chkc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [135:0] v, input bit lng,
                             input bit chkc, input int idle);
        logic [135:0] e;
        int d0, t0, len;
        exp_q.push_back(model(v, lng, chkc));
        d0 = n_done;
        t0 = n_to;
        pulse_start(lng, chkc);
        chk({tag, "_busy"}, 128'(bus.busy), 128'd1);
        repeat (idle) begin
            bus.cmd_in = 1'b1;
            tick();
        end
        len = lng ? 136 : 48;
        for (int i = len - 1; i >= 0; i--) begin
            bus.cmd_in = v[i];
            tick();
        end
        bus.cmd_in = 1'b1;
        chk({tag, "_early_pulse"}, 128'((n_done - d0) + (n_to - t0)), 128'd0);
        tick();
        chk({tag, "_done"}, 128'(bus.resp_done), 128'd1);
        e = exp_q.pop_front();
        chk({tag, "_crc_err"}, 128'(bus.resp_crc_err), 128'(e[135]));
        chk({tag, "_end_err"}, 128'(bus.resp_end_err), 128'(e[134]));
        chk({tag, "_idx"}, 128'(bus.resp_idx), 128'(e[133:128]));
        chk({tag, "_data"}, bus.resp_data, e[127:0]);
        chk({tag, "_no_timeout"}, 128'(n_to - t0), 128'd0);
        last_idx  = e[133:128];
        last_data = e[127:0];
    endtask

    initial begin
        int d0, t0, first_to;
        bus.start = 1'b0;
        bus.long_resp = 1'b0;
        bus.crc_chk = 1'b0;
        bus.cmd_in = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_done", 128'(bus.resp_done), 128'd0);
        chk("rst_timeout", 128'(bus.resp_timeout), 128'd0);
        chk("rst_idx", 128'(bus.resp_idx), 128'd0);
        chk("rst_data", bus.resp_data, 128'd0);
        chk("rst_state", 128'(state), 128'(ST_IDLE));
        rstn = 1'b1;
        tick();

        f = {88'b0, 48'h48_0000_01AA_87};
        run_frame("r7", f, 1'b0, 1'b1, 5);
        chk("r7_idx_const", 128'(bus.resp_idx), 128'd8);
        chk("r7_arg_const", bus.resp_data, 128'h1AA);
        f[10] = ~f[10];
        run_frame("r7_flip_chk", f, 1'b0, 1'b1, 5);
        run_frame("r7_flip_nochk", f, 1'b0, 1'b0, 5);

        // Timeout: no start bit ever arrives.
        d0 = n_done;
        t0 = n_to;
        first_to = -1;
        pulse_start(1'b0, 1'b1);
        bus.cmd_in = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (bus.resp_timeout === 1'b1 && first_to < 0) first_to = k;
        end
        chk("to_cycle", 128'(first_to), 128'(NCR));
        chk("to_count", 128'(n_to - t0), 128'd1);
        chk("to_no_done", 128'(n_done - d0), 128'd0);
        chk("to_idle", 128'(bus.busy), 128'd0);
        chk("to_idx_hold", 128'(bus.resp_idx), 128'(last_idx));
        chk("to_data_hold", bus.resp_data, last_data);

        f = make_short(6'($urandom_range(0, 63)), $urandom(), 1'b0);
        run_frame("start_last_cycle", f, 1'b0, 1'b1, NCR - 1);

        run_frame("end_err", {88'b0, 48'h40_0000_0000_94}, 1'b0, 1'b1, 2);

        f = make_long({$urandom(), $urandom(), $urandom(), $urandom()});
        run_frame("r2", f, 1'b1, 1'b1, 3);
        chk("r2_idx_const", 128'(bus.resp_idx), 128'h3F);
        f[60] = ~f[60];
        run_frame("r2_bad", f, 1'b1, 1'b1, 0);
        run_frame("r2_bad_nochk", f, 1'b1, 1'b0, 1);

        for (int n = 0; n < 6; n++) begin
            f = make_short(6'($urandom_range(0, 63)), $urandom(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                pos = $urandom_range(0, 46);
                f[pos] = ~f[pos];
            end
            run_frame("rand_short", f, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 10));
        end

        // Reset in the middle of a frame.
        f = make_short(6'd17, 32'hDEAD_BEEF, 1'b0);
        d0 = n_done;
        t0 = n_to;
        pulse_start(1'b0, 1'b1);
        repeat (5) begin
            bus.cmd_in = 1'b1;
            tick();
        end
        for (int i = 47; i >= 20; i--) begin
            bus.cmd_in = f[i];
            tick();
        end
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(bus.busy), 128'd0);
        chk("mid_rst_idx", 128'(bus.resp_idx), 128'd0);
        chk("mid_rst_data", bus.resp_data, 128'd0);
        chk("mid_rst_errs", 128'({bus.resp_crc_err, bus.resp_end_err}), 128'd0);
        chk("mid_rst_state", 128'(state), 128'(ST_IDLE));
        bus.cmd_in = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        repeat (4) tick();
        chk("mid_rst_no_pulse", 128'((n_done - d0) + (n_to - t0)), 128'd0);
        run_frame("after_rst", f, 1'b0, 1'b1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
